// File: rtl/cgra_mem_port_arbiter.sv
// Round-robin arbiter of N CGRA load/store ports onto one single-ported SRAM bank,
// plus an idle-driven retention FSM. Optional counters: CGRA_MEM_ARB_PERF_CNT_EN.
module cgra_mem_port_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int NUM_WORDS       = 1024,
  parameter int RET_IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES     = 2,
  localparam int AddrWidth      = ($clog2(NUM_WORDS) < 1) ? 1 : $clog2(NUM_WORDS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PORTS-1:0]           req_i,
  input  logic [NUM_PORTS-1:0]           we_i,
  input  logic [NUM_PORTS*AddrWidth-1:0] addr_i,
  input  logic [NUM_PORTS*32-1:0]        wdata_i,
  input  logic [NUM_PORTS*4-1:0]         be_i,
  output logic [NUM_PORTS-1:0]           gnt_o,
  output logic [NUM_PORTS-1:0]           rvalid_o,
  output logic [31:0]                    rdata_o,
  output logic                           sram_req_o,
  output logic                           sram_we_o,
  output logic [AddrWidth-1:0]           sram_addr_o,
  output logic [31:0]                    sram_wdata_o,
  output logic [3:0]                     sram_be_o,
  input  logic [31:0]                    sram_rdata_i,
  output logic                           sram_set_retentive_no,
  output logic                           busy_o,
`ifdef CGRA_MEM_ARB_PERF_CNT_EN
  input  logic                           perf_clr_i,
  output logic [31:0]                    perf_grant_cnt_o,
  output logic [31:0]                    perf_stall_cnt_o,
`endif
  output logic [1:0]                     dbg_state_o
);

  localparam int PtrW  = $clog2(NUM_PORTS);
  localparam int IdleW = (RET_IDLE_CYCLES < 1) ? 1 : $clog2(RET_IDLE_CYCLES + 1);
  localparam int WakeW = 4;

  typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_RET = 2'd1, ST_WAKE = 2'd2} ret_state_e;

  ret_state_e       state_q, state_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WakeW-1:0] wake_cnt_q, wake_cnt_d;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic             rd_pend_q;

  logic             win_found;
  logic [PtrW-1:0]  win_idx;
  logic             grant_en;
  int               scan;

  // Handshake: a port's request is accepted in the cycle gnt_o[p] is high (req may
  // drop any time before that); exactly one cycle later rvalid_o[p] pulses with rdata_o.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan = int'(rr_ptr_q) + i;
      if (scan >= NUM_PORTS) scan = scan - NUM_PORTS;
      if (!win_found && req_i[scan]) begin
        win_found = 1'b1;
        win_idx   = PtrW'(scan);
      end
    end
  end

  assign grant_en = win_found && (state_q == ST_ACTIVE) && !rst_i;

  always_comb begin
    gnt_o        = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    rr_ptr_d     = rr_ptr_q;
    if (grant_en) begin
      gnt_o[win_idx] = 1'b1;
      sram_req_o     = 1'b1;
      sram_we_o      = we_i[win_idx];
      sram_addr_o    = addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
      sram_wdata_o   = wdata_i[int'(win_idx)*32 +: 32];
      sram_be_o      = be_i[int'(win_idx)*4 +: 4];
      rr_ptr_d       = (win_idx == PtrW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Retention FSM: idle-driven entry, request-driven exit through a fixed wake window.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      ST_ACTIVE: begin
        if (|req_i) begin
          idle_cnt_d = '0;
        end else if (!(|rvalid_q) && idle_cnt_q != IdleW'(RET_IDLE_CYCLES)) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        if (RET_IDLE_CYCLES != 0 && idle_cnt_q == IdleW'(RET_IDLE_CYCLES)) state_d = ST_RET;
      end
      ST_RET: begin
        if (|req_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WakeW'(WAKE_CYCLES);
        end
      end
      ST_WAKE: begin
        if (wake_cnt_q <= WakeW'(1)) begin
          state_d    = ST_ACTIVE;
          idle_cnt_d = '0;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ACTIVE;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      rvalid_q   <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid_q   <= gnt_o;
      rd_pend_q  <= grant_en && !we_i[win_idx];
    end
  end

  // Responses are masked during reset so a pending one is dropped immediately.
  assign rvalid_o              = rst_i ? '0 : rvalid_q;
  assign rdata_o               = (rd_pend_q && !rst_i) ? sram_rdata_i : 32'd0;
  assign sram_set_retentive_no = (state_q != ST_RET);
  assign busy_o                = (|req_i) | (|rvalid_o);
  assign dbg_state_o           = state_q;

`ifdef CGRA_MEM_ARB_PERF_CNT_EN
  logic [31:0] grant_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = |(req_i & ~gnt_o);

  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (grant_en && grant_cnt_q != 32'hFFFF_FFFF) grant_cnt_q <= grant_cnt_q + 32'd1;
      if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_grant_cnt_o = grant_cnt_q;
  assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cgra_mem_port_arbiter.sv
// Bench for cgra_mem_port_arbiter: per-port transaction queues, bank model, and a
// response scoreboard fed on every grant and drained on every rvalid.
module tb_cgra_mem_port_arbiter;
  localparam int NP   = 4;
  localparam int NW   = 1024;
  localparam int AW   = 10;
  localparam int RETC = 4;
  localparam int WAKC = 2;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
  } txn_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [NP-1:0]    req_i = '0, we_i = '0;
  logic [NP*AW-1:0] addr_i = '0;
  logic [NP*32-1:0] wdata_i = '0;
  logic [NP*4-1:0]  be_i = '0;
  logic [NP-1:0]    gnt_o, rvalid_o;
  logic [31:0]      rdata_o;
  logic             sram_req_o, sram_we_o;
  logic [AW-1:0]    sram_addr_o;
  logic [31:0]      sram_wdata_o;
  logic [3:0]       sram_be_o;
  logic [31:0]      sram_rdata_i = '0;
  logic             sram_set_retentive_no, busy_o;
  logic [1:0]       dbg_state_o;
`ifdef CGRA_MEM_ARB_PERF_CNT_EN
  logic             perf_clr_i = 1'b0;
  logic [31:0]      perf_grant_cnt_o, perf_stall_cnt_o;
`endif

  cgra_mem_port_arbiter #(
    .NUM_PORTS(NP), .NUM_WORDS(NW), .RET_IDLE_CYCLES(RETC), .WAKE_CYCLES(WAKC)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .sram_req_o(sram_req_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
    .sram_rdata_i(sram_rdata_i), .sram_set_retentive_no(sram_set_retentive_no),
    .busy_o(busy_o),
`ifdef CGRA_MEM_ARB_PERF_CNT_EN
    .perf_clr_i(perf_clr_i), .perf_grant_cnt_o(perf_grant_cnt_o),
    .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- shared bench state ----------------
  txn_t        port_q[NP][$];
  logic [39:0] exp_q[$];           // {port[7:0], data[31:0]}
  int          hist_port[$];
  int          hist_cyc[$];
  logic [NP-1:0] gnt_seen = '0;
  logic [31:0] bank_mem[16];
  logic [31:0] ref_mem[16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      bank_mem[i] = 32'h1000_0000 + i;
      ref_mem[i]  = 32'h1000_0000 + i;
    end
  end

  // Bank model: 1-cycle read latency, garbage on the data bus otherwise.
  always @(posedge clk) begin
    if (sram_req_o && sram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (sram_be_o[b]) bank_mem[sram_addr_o[3:0]][8*b +: 8] = sram_wdata_o[8*b +: 8];
      sram_rdata_i <= $urandom();
    end else if (sram_req_o) begin
      sram_rdata_i <= bank_mem[sram_addr_o[3:0]];
    end else begin
      sram_rdata_i <= $urandom();
    end
  end

  // ---------------- driver ----------------
  txn_t drv_t;
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (gnt_seen[p] && port_q[p].size() > 0) void'(port_q[p].pop_front());
      if (port_q[p].size() > 0) begin
        drv_t = port_q[p][0];
        req_i[p] = 1'b1;
        we_i[p]  = drv_t.we;
        addr_i[p*AW +: AW]  = drv_t.addr;
        wdata_i[p*32 +: 32] = drv_t.wdata;
        be_i[p*4 +: 4]      = drv_t.be;
      end else begin
        req_i[p] = 1'b0;
        we_i[p]  = 1'b0;
        addr_i[p*AW +: AW]  = '0;
        wdata_i[p*32 +: 32] = '0;
        be_i[p*4 +: 4]      = '0;
      end
    end
  end

  task automatic push_txn(input int p, input logic we, input int addr, input logic [31:0] wd,
                          input logic [3:0] be);
    txn_t t;
    t.we = we; t.addr = AW'(addr); t.wdata = wd; t.be = be;
    port_q[p].push_back(t);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [39:0] mon_e;
  logic        mon_had;
  int          mon_w;
  logic [31:0] mon_d;
  logic [3:0]  mon_a;
  always @(negedge clk) begin
    if (rst_i) begin
      check_eq("rst_gnt", 64'(gnt_o), 64'd0);
      check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
      check_eq("rst_sram_req", 64'(sram_req_o), 64'd0);
      exp_q.delete();
      gnt_seen = '0;
    end else begin
      mon_had = (exp_q.size() > 0);
      if (mon_had) begin
        mon_e = exp_q.pop_front();
        check_eq("rvalid", 64'(rvalid_o), 64'(1 << mon_e[39:32]));
        check_eq("rdata", 64'(rdata_o), 64'(mon_e[31:0]));
      end else begin
        check_eq("rvalid_idle", 64'(rvalid_o), 64'd0);
      end
      check_eq("busy", 64'(busy_o), 64'((|req_i) || mon_had));
      if (gnt_o != '0) begin
        mon_w = 0;
        for (int p = NP - 1; p >= 0; p--) if (gnt_o[p]) mon_w = p;
        check_eq("gnt_onehot", 64'($countones(gnt_o)), 64'd1);
        check_eq("gnt_req", 64'(req_i[mon_w]), 64'd1);
        check_eq("sram_mux", {sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o},
                 {1'b1, we_i[mon_w], addr_i[mon_w*AW +: AW], wdata_i[mon_w*32 +: 32],
                  be_i[mon_w*4 +: 4]});
        mon_a = addr_i[mon_w*AW +: 4];
        if (we_i[mon_w]) begin
          for (int b = 0; b < 4; b++)
            if (be_i[mon_w*4 + b]) ref_mem[mon_a][8*b +: 8] = wdata_i[mon_w*32 + 8*b +: 8];
          mon_d = 32'd0;
        end else begin
          mon_d = ref_mem[mon_a];
        end
        exp_q.push_back({8'(mon_w), mon_d});
        hist_port.push_back(mon_w);
        hist_cyc.push_back(cyc);
      end else begin
        check_eq("sram_idle", {sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o}, 64'd0);
      end
      gnt_seen = gnt_o;
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    for (int p = 0; p < NP; p++) port_q[p].delete();
    repeat (2) tick();
    hist_port.delete();
    hist_cyc.delete();
    rst_i = 1'b0;
  endtask

  task automatic wait_hist(input int n, input string tag);
    int k;
    k = 0;
    while (hist_port.size() < n && k < 60) begin
      tick();
      k++;
    end
    if (hist_port.size() < n) check_eq(tag, 64'(hist_port.size()), 64'(n));
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    // Reset state
    do_reset();
    check_eq("reset_ret_pin", 64'(sram_set_retentive_no), 64'd1);
    check_eq("reset_state", 64'(dbg_state_o), 64'd0);
    check_eq("reset_rvalid", 64'(rvalid_o), 64'd0);

    // Write then read back on port 1
    push_txn(1, 1'b1, 'h010, 32'hDEAD_BEEF, 4'hF);
    push_txn(1, 1'b0, 'h010, 32'h0, 4'hF);
    wait_hist(2, "wr_rd_timeout");
    repeat (2) tick();
    check_eq("wr_rd_port0", 64'(hist_port[0]), 64'd1);
    check_eq("wr_rd_port1", 64'(hist_port[1]), 64'd1);
    check_eq("wr_rd_b2b", 64'(hist_cyc[1] - hist_cyc[0]), 64'd1);

    // All four ports reading continuously
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) push_txn(p, 1'b0, p, 32'h0, 4'hF);
    wait_hist(12, "rr_timeout");
    repeat (2) tick();
    for (int i = 0; i < 12; i++) begin
      check_eq("rr_order", 64'(hist_port[i]), 64'(i % NP));
      check_eq("rr_rate", 64'(hist_cyc[i] - hist_cyc[0]), 64'(i));
    end

    // Retention entry after idle, wake on port 2 request
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k <= 3) check_eq("ret_pin_high", 64'(sram_set_retentive_no), 64'd1);
      if (k >= 5) begin
        check_eq("ret_pin_low", 64'(sram_set_retentive_no), 64'd0);
        check_eq("ret_state", 64'(dbg_state_o), 64'd1);
      end
    end
    push_txn(2, 1'b0, 3, 32'h0, 4'hF);
    tick();
    check_eq("wake_req_pin", 64'(sram_set_retentive_no), 64'd0);
    check_eq("wake_req_gnt", 64'(gnt_o), 64'd0);
    tick();
    check_eq("wake_pin", 64'(sram_set_retentive_no), 64'd1);
    check_eq("wake_state", 64'(dbg_state_o), 64'd2);
    check_eq("wake_gnt1", 64'(gnt_o), 64'd0);
    tick();
    check_eq("wake_gnt2", 64'(gnt_o), 64'd0);
    tick();
    check_eq("wake_gnt_p2", 64'(gnt_o), 64'b0100);
    repeat (2) tick();

    // Reset while a read response is pending
    do_reset();
    push_txn(1, 1'b0, 5, 32'h0, 4'hF);
    wait_hist(1, "rst_drop_timeout");
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    for (int p = 0; p < NP; p++) port_q[p].delete();
    tick();
    check_eq("rst_drop_rvalid", 64'(rvalid_o), 64'd0);
    check_eq("rst_drop_rdata", 64'(rdata_o), 64'd0);
    tick();
    hist_port.delete();
    hist_cyc.delete();
    rst_i = 1'b0;
    tick();
    check_eq("post_rst_rvalid", 64'(rvalid_o), 64'd0);
    push_txn(0, 1'b0, 1, 32'h0, 4'hF);
    push_txn(3, 1'b0, 2, 32'h0, 4'hF);
    wait_hist(2, "post_rst_timeout");
    check_eq("post_rst_first", 64'(hist_port[0]), 64'd0);
    check_eq("post_rst_second", 64'(hist_port[1]), 64'd3);
    repeat (2) tick();

    // Wrap-around from rr_ptr=1: port 3 before port 0
    do_reset();
    push_txn(0, 1'b1, 7, 32'hCAFE_0007, 4'h3);
    wait_hist(1, "wrap_setup_timeout");
    tick();
`ifdef CGRA_MEM_ARB_PERF_CNT_EN
    perf_clr_i = 1'b1;
    tick();
    perf_clr_i = 1'b0;
`endif
    push_txn(0, 1'b0, 7, 32'h0, 4'hF);
    push_txn(3, 1'b0, 7, 32'h0, 4'hF);
    wait_hist(3, "wrap_timeout");
    repeat (2) tick();
    check_eq("wrap_first", 64'(hist_port[1]), 64'd3);
    check_eq("wrap_second", 64'(hist_port[2]), 64'd0);
    check_eq("wrap_b2b", 64'(hist_cyc[2] - hist_cyc[1]), 64'd1);
`ifdef CGRA_MEM_ARB_PERF_CNT_EN
    check_eq("perf_grants", 64'(perf_grant_cnt_o), 64'd2);
    check_eq("perf_stalls", 64'(perf_stall_cnt_o), 64'd1);
`endif

    // Random mixed traffic, including idle gaps that enter retention
    do_reset();
    for (int it = 0; it < 120; it++) begin
      tick();
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) == 0 && port_q[p].size() < 3 && (it % 40) < 30)
          push_txn(p, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom(),
                   4'($urandom_range(0, 15)));
    end
    begin
      int k;
      k = 0;
      while ((port_q[0].size() + port_q[1].size() + port_q[2].size() + port_q[3].size() +
              exp_q.size()) != 0 && k < 400) begin
        tick();
        k++;
      end
      check_eq("drain_ports", 64'(port_q[0].size() + port_q[1].size() + port_q[2].size() +
                                  port_q[3].size()), 64'd0);
    end
    repeat (2) tick();
    check_eq("final_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cgra_mem_port_arbiter.md
Name: cgra_mem_port_arbiter

Overview:
Upstream stage of the CGRA SRAM bank wrapper. Arbitrates N CGRA load/store ports onto a single-ported bank (1-cycle read latency) using round-robin with OBI-style gnt/rvalid handshakes. Also contains an idle-driven retention FSM that drives the bank's active-low retention input. One instance per CGRA memory bank.

Parameters:
NUM_PORTS, 4, number of CGRA requester ports (2..8)
NUM_WORDS, 1024, bank depth in words; AddrWidth = max(1, clog2(NUM_WORDS))
RET_IDLE_CYCLES, 64, consecutive idle cycles before entering retention; 0 disables retention
WAKE_CYCLES, 2, cycles grants stay blocked after leaving retention (1..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  NUM_PORTS  per-port request
we_i  in  NUM_PORTS  per-port write enable
addr_i  in  NUM_PORTS*AddrWidth  per-port word address, port p at [p*AddrWidth +: AddrWidth]
wdata_i  in  NUM_PORTS*32  per-port write data
be_i  in  NUM_PORTS*4  per-port byte enables
gnt_o  out  NUM_PORTS  one-hot grant, combinational, same cycle as the accepted request
rvalid_o  out  NUM_PORTS  one-hot response valid, one cycle after grant
rdata_o  out  32  response data, shared across ports
sram_req_o  out  1  bank request
sram_we_o  out  1  bank write enable
sram_addr_o  out  AddrWidth  bank address
sram_wdata_o  out  32  bank write data
sram_be_o  out  4  bank byte enables
sram_rdata_i  in  32  bank read data, valid the cycle after a read request
sram_set_retentive_no  out  1  active-low retention request to the bank
busy_o  out  1  high when any req_i is high or any response is pending

Behaviour:
- Reset (rst_i high at a clock edge): rr_ptr=0, state=ACTIVE, idle_cnt=0, wake_cnt=0, rvalid_o=0, rdata_o=0, sram_set_retentive_no=1. gnt_o and sram_req_o are forced to 0 while rst_i is high. A response pending at reset is dropped.
- Arbitration: the first requesting port scanning upward from rr_ptr (with wrap) wins. gnt_o[w]=1 and sram_req_o=1; the bank signals mux in port w's we/addr/wdata/be. On grant, rr_ptr <= (w+1) mod NUM_PORTS. With no requests, rr_ptr holds, sram_req_o=0, and sram_we/addr/wdata/be=0.
- Granting is blocked (gnt_o=0, sram_req_o=0) in states RET and WAKE.
- Response: for a grant in cycle t, rvalid_o[w]=1 in cycle t+1, for reads and writes alike. Read: rdata_o=sram_rdata_i. Write: rdata_o=0. Back-to-back grants overlap, giving a throughput of one per cycle.
- A requester may drop req_i without a grant; there is no obligation to hold.
- Retention FSM, states ACTIVE, RET, WAKE:
  - ACTIVE: idle_cnt increments on a cycle with no req_i and no pending rvalid, saturating at RET_IDLE_CYCLES. Any request clears it to 0. When idle_cnt==RET_IDLE_CYCLES and RET_IDLE_CYCLES!=0, go to RET.
  - RET: sram_set_retentive_no=0. Any req_i high: go to WAKE, load wake_cnt=WAKE_CYCLES, set sram_set_retentive_no=1.
  - WAKE: decrement wake_cnt. At wake_cnt==1, go to ACTIVE with idle_cnt=0. The first grant is possible in the cycle after leaving WAKE.
  - If requests drop during WAKE, the FSM still completes WAKE and returns to ACTIVE.
  - With RET_IDLE_CYCLES=0, the FSM never leaves ACTIVE.
- busy_o = |req_i | (|rvalid_o).

Optional Feature:
CGRA_MEM_ARB_PERF_CNT_EN. When defined, adds:
- output perf_grant_cnt_o [31:0]: increments on each grant.
- output perf_stall_cnt_o [31:0]: increments each cycle where some requesting port is not granted, counted once per cycle.
- input perf_clr_i [1]: synchronous clear.
- Both counters saturate at 0xFFFFFFFF and reset to 0.

When not defined, these ports and the counters do not exist.

Test Plan:
- Port 1 write addr 0x010, wdata 0xDEADBEEF, be 0xF; then read 0x010 -> cycle t: gnt_o=0b0010, sram_we_o=1; t+1: rvalid_o=0b0010, rdata_o=0; read returns rdata_o=0xDEADBEEF one cycle after its grant.
- NUM_PORTS=4, all ports reading continuously from reset -> grant order 0,1,2,3,0,... with one grant per cycle; each rvalid_o one cycle after its gnt_o.
- RET_IDLE_CYCLES=4, no requests -> sram_set_retentive_no falls after 4 idle cycles. A port 2 request then -> retention pin rises next cycle; with WAKE_CYCLES=2, gnt_o[2] appears 3 cycles after req rises (1 cycle RET exit + 2 WAKE).
- Read granted at t, rst_i high at t+1 -> rvalid_o=0 at t+1 and after; rr_ptr=0, so port 0 wins next contention.
- Ports 0 and 3 request, rr_ptr=1 -> port 3 granted first, then port 0. With CGRA_MEM_ARB_PERF_CNT_EN: perf_stall_cnt_o=1 and perf_grant_cnt_o=2 afterwards.
